// File: rtl/led_pkg.sv
// Shared definitions for the LED row scanner: default geometry, scan state
// encoding and the all-off column word.
package led_pkg;

   localparam int ROWS_DEF     = 8;
   localparam int COLS_DEF     = 8;
   // Widest column word col_off can describe; callers cast down to COLS.
   localparam int COL_WORD_MAX = 64;

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_DRIVE = 1'b1
   } state_t;

   // Column word that leaves every LED in a row dark.
   function automatic logic [COL_WORD_MAX-1:0] col_off(input logic active_low);
      logic [COL_WORD_MAX-1:0] word;
      if (active_low) begin
         word = {COL_WORD_MAX{1'b1}};
      end else begin
         word = {COL_WORD_MAX{1'b0}};
      end
      return word;
   endfunction

endpackage

// File: rtl/led_frame_buffer.sv
// Double buffer for the LED scanner: a shadow frame accepted over a
// valid/ready handshake, and the active frame that is only replaced on swap.
module led_frame_buffer #(
   parameter int N = 64
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic [N-1:0] frame_data_i,
   input  logic         frame_valid_i,
   input  logic         swap_i,
   output logic         frame_ready_o,
   output logic [N-1:0] active_o
);

   logic [N-1:0] shadow_q, shadow_d;
   logic [N-1:0] active_q, active_d;
   // ready_q is high while the shadow is empty (the inverse of shadow_full).
   logic         ready_q,  ready_d;

   // Swap a pending shadow into the active buffer, otherwise accept a load.
   // A swap needs a full shadow and a load needs an empty one, so they never collide.
   always_comb begin
      shadow_d = shadow_q;
      active_d = active_q;
      ready_d  = ready_q;
      if (swap_i && !ready_q) begin
         active_d = shadow_q;
         ready_d  = 1'b1;
      end else if (frame_valid_i && ready_q) begin
         shadow_d = frame_data_i;
         ready_d  = 1'b0;
      end else begin
         ready_d  = ready_q;
      end
   end

   // Buffer registers; reset discards any pending frame and blanks the display.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         shadow_q <= {N{1'b0}};
         active_q <= {N{1'b0}};
         ready_q  <= 1'b1;
      end else begin
         shadow_q <= shadow_d;
         active_q <= active_d;
         ready_q  <= ready_d;
      end
   end

   assign frame_ready_o = ready_q;
   assign active_o      = active_q;

endmodule

// File: rtl/led_row_scanner.sv
// LED matrix row scanner: blanks, then drives each row of the active frame
// for a fixed dwell, and swaps in a new frame only after the last row.
module led_row_scanner
   import led_pkg::*;
#(
   parameter int ROWS           = ROWS_DEF,
   parameter int COLS           = COLS_DEF,
   parameter int DWELL          = 1000,
   parameter int BLANK          = 2,
   parameter int COL_ACTIVE_LOW = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [ROWS*COLS-1:0] frame_data,
   input  logic                 frame_valid,
   output logic                 frame_ready,
   output logic                 frame_done,
   output logic [ROWS-1:0]      row,
   output logic [COLS-1:0]      column
);

   localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
   // The counter holds the full phase length, so it needs CNT_MAX+1 codes.
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int IDX_W   = (ROWS > 1) ? $clog2(ROWS) : 1;

   localparam logic [CNT_W-1:0] DWELL_C  = CNT_W'(DWELL);
   localparam logic [CNT_W-1:0] BLANK_C  = CNT_W'(BLANK);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
   localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
   localparam logic [ROWS-1:0]  ROW_ONE  = ROWS'(1);
   localparam logic [ROWS-1:0]  ROW_OFF  = ROWS'(0);
   localparam logic [COLS-1:0]  COL_OFF  = COLS'(col_off(COL_ACTIVE_LOW != 0));

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q,   cnt_d;
   logic [IDX_W-1:0]   idx_q,   idx_d;
   logic [ROWS-1:0]    row_q,   row_d;
   logic [COLS-1:0]    col_q,   col_d;
   logic               done_q,  done_d;
   logic [ROWS*COLS-1:0] active_s;

   // The boundary cycle is flagged by done_q; the buffer swaps at its closing edge.
   led_frame_buffer #(
      .N (ROWS*COLS)
   ) u_frame_buffer (
      .clk_i         (clk),
      .rst_ni        (rst),
      .frame_data_i  (frame_data),
      .frame_valid_i (frame_valid),
      .swap_i        (done_q),
      .frame_ready_o (frame_ready),
      .active_o      (active_s)
   );

   // Phase sequencing on one down-counter: a phase ends when the count is 1.
   // A count of 0 only exists right after reset and loads the current phase,
   // which makes the first blank after reset one cycle longer.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      if (cnt_q == CNT_ZERO) begin
         cnt_d = (state_q == ST_DRIVE) ? DWELL_C : BLANK_C;
      end else if (cnt_q == CNT_ONE) begin
         if (state_q == ST_BLANK) begin
            state_d = ST_DRIVE;
            cnt_d   = DWELL_C;
         end else begin
            state_d = ST_BLANK;
            cnt_d   = BLANK_C;
            idx_d   = (idx_q == LAST_IDX) ? IDX_ZERO : idx_q + IDX_ONE;
         end
      end else begin
         cnt_d = cnt_q - CNT_ONE;
      end
   end

   // Output drive for the next cycle, so row/column/done stay registered and
   // change in the same cycle as the state.
   always_comb begin
      row_d  = ROW_OFF;
      col_d  = COL_OFF;
      done_d = 1'b0;
      if (state_d == ST_DRIVE) begin
         row_d  = ROW_ONE << idx_d;
         col_d  = active_s[int'(idx_d)*COLS +: COLS] ^ COL_OFF;
         done_d = (idx_d == LAST_IDX) && (cnt_d == CNT_ONE);
      end else begin
         row_d  = ROW_OFF;
         col_d  = COL_OFF;
         done_d = 1'b0;
      end
   end

   // Scan state and output registers; reset may land mid-frame and blanks at once.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_BLANK;
         cnt_q   <= CNT_ZERO;
         idx_q   <= IDX_ZERO;
         row_q   <= ROW_OFF;
         col_q   <= COL_OFF;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         row_q   <= row_d;
         col_q   <= col_d;
         done_q  <= done_d;
      end
   end

   assign row        = row_q;
   assign column     = col_q;
   assign frame_done = done_q;

endmodule
